// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC strobes, the instruction-memory req/ack port and the
// valid/ready issue to decode. Define FETCH_COUNT_EN to add the saturating fetchCount output.
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  input  logic [ADDR_WIDTH-1:0] pcValue,
  output logic                  pcWriteEn,
  output logic                  pcIncEn,
  output logic [ADDR_WIDTH-1:0] pcDataIn,
  output logic                  memReq,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic                  memAck,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic                  instrValid,
  input  logic                  instrReady,
  output logic [DATA_WIDTH-1:0] irData,
  input  logic                  jumpEn,
  input  logic [ADDR_WIDTH-1:0] jumpAddr,
  output logic                  busy,
`ifdef FETCH_COUNT_EN
  output logic [15:0]           fetchCount,
`endif
  output logic                  fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         wait_q, wait_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  halt_pending_q, halt_pending_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      wait_q         <= '0;
      // NOTE: the instruction register is reset explicitly because irData must read 0 in reset.
      ir_q           <= '0;
      halt_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      ir_q           <= ir_d;
      halt_pending_q <= halt_pending_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    state_d        = state_q;
    wait_d         = wait_q;
    ir_d           = ir_q;
    halt_pending_d = halt_pending_q;
    memReq         = 1'b0;
    memAddr        = '0;
    pcIncEn        = 1'b0;
    pcWriteEn      = 1'b0;
    pcDataIn       = '0;
    instrValid     = 1'b0;
    fault          = 1'b0;

    unique case (state_q)
      IDLE: begin
        halt_pending_d = 1'b0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        memReq  = 1'b1;
        memAddr = pcValue;
        if (halt) halt_pending_d = 1'b1;
        if (memAck) begin
          ir_d    = memData;
          pcIncEn = 1'b1;
          wait_d  = '0;
          state_d = ISSUE;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_d == CW'(TIMEOUT)) state_d = FAULT;
        end
      end
      ISSUE: begin
        instrValid = 1'b1;
        if (halt) halt_pending_d = 1'b1;
        if (instrReady) begin
          if (jumpEn) begin
            pcWriteEn = 1'b1;
            pcDataIn  = jumpAddr;
          end
          // A halt arriving on the handshake cycle itself still stops after this instruction.
          state_d = (halt_pending_q || halt) ? IDLE : FETCH;
        end
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign irData = ir_q;

`ifdef FETCH_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (state_q == FETCH && memAck && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign fetchCount = count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a cycle table for the main fetch/issue flow plus
// hand sequences for memory timeout and asynchronous reset.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        rst;
  logic        start, halt, memAck, instrReady, jumpEn;
  logic [11:0] pcValue, jumpAddr;
  logic [15:0] memData;
  logic        pcWriteEn, pcIncEn, memReq, instrValid, busy, fault;
  logic [11:0] pcDataIn, memAddr;
  logic [15:0] irData;
`ifdef FETCH_COUNT_EN
  logic [15:0] fetchCount;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fetch_sequencer #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .TIMEOUT(15)) dut (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .halt      (halt),
    .pcValue   (pcValue),
    .pcWriteEn (pcWriteEn),
    .pcIncEn   (pcIncEn),
    .pcDataIn  (pcDataIn),
    .memReq    (memReq),
    .memAddr   (memAddr),
    .memAck    (memAck),
    .memData   (memData),
    .instrValid(instrValid),
    .instrReady(instrReady),
    .irData    (irData),
    .jumpEn    (jumpEn),
    .jumpAddr  (jumpAddr),
    .busy      (busy),
`ifdef FETCH_COUNT_EN
    .fetchCount(fetchCount),
`endif
    .fault     (fault)
  );

  // PC register model: load has priority over increment.
  logic [11:0] pc_m = 12'h100;
  always @(posedge clock) begin
    if (pcWriteEn)    pc_m <= pcDataIn;
    else if (pcIncEn) pc_m <= pc_m + 12'd1;
  end
  assign pcValue = pc_m;

  typedef struct {
    string       name;
    logic        start, halt, ack, ready, jen;
    logic [15:0] mdata;
    logic [11:0] jaddr;
    logic [45:0] exp;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [45:0] pack(logic mreq, logic [11:0] maddr, logic inc, logic wr,
                                       logic [11:0] pdata, logic iv, logic [15:0] ir,
                                       logic bsy, logic flt);
    return {mreq, maddr, inc, wr, pdata, iv, ir, bsy, flt};
  endfunction

  function automatic logic [45:0] outs();
    return pack(memReq, memAddr, pcIncEn, pcWriteEn, pcDataIn, instrValid, irData, busy, fault);
  endfunction

  function automatic vec_t mk(string n, logic s, logic h, logic a, logic r, logic j,
                              logic [15:0] md, logic [11:0] ja, logic [45:0] e);
    vec_t v;
    v.name = n; v.start = s; v.halt = h; v.ack = a; v.ready = r; v.jen = j;
    v.mdata = md; v.jaddr = ja; v.exp = e;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic s, logic h, logic a, logic r, logic j, logic [15:0] md, logic [11:0] ja);
    start = s; halt = h; memAck = a; instrReady = r; jumpEn = j; memData = md; jumpAddr = ja;
  endtask

  initial begin
    int n_req;
    drive(0, 0, 0, 0, 0, 16'h0, 12'h0);
    rst = 1'b0;
    #1;
    check("reset_outputs", 64'(outs()), 64'(pack(0, 0, 0, 0, 0, 0, 0, 0, 0)));
`ifdef FETCH_COUNT_EN
    check("reset_count", 64'(fetchCount), 64'd0);
`endif

    //                 name            st h  ak rd jn mdata     jaddr     mreq maddr   inc wr pdata   iv ir        bsy flt
    vecs[0]  = mk("idle_start",   1, 0, 0, 0, 0, 16'h0000, 12'h000, pack(0, 12'h000, 0, 0, 12'h000, 0, 16'h0000, 0, 0));
    vecs[1]  = mk("fetch_zero",   0, 0, 1, 0, 0, 16'hA5A5, 12'h000, pack(1, 12'h100, 1, 0, 12'h000, 0, 16'h0000, 1, 0));
    vecs[2]  = mk("issue_first",  0, 0, 0, 1, 0, 16'h0000, 12'h000, pack(0, 12'h000, 0, 0, 12'h000, 1, 16'hA5A5, 1, 0));
    vecs[3]  = mk("wait_1",       0, 0, 0, 0, 0, 16'h0000, 12'h000, pack(1, 12'h101, 0, 0, 12'h000, 0, 16'hA5A5, 1, 0));
    vecs[4]  = mk("wait_2",       0, 0, 0, 0, 0, 16'h0000, 12'h000, pack(1, 12'h101, 0, 0, 12'h000, 0, 16'hA5A5, 1, 0));
    vecs[5]  = mk("wait_3",       0, 0, 0, 0, 0, 16'h0000, 12'h000, pack(1, 12'h101, 0, 0, 12'h000, 0, 16'hA5A5, 1, 0));
    vecs[6]  = mk("ack_late",     0, 0, 1, 0, 0, 16'h1234, 12'h000, pack(1, 12'h101, 1, 0, 12'h000, 0, 16'hA5A5, 1, 0));
    vecs[7]  = mk("jump_load",    0, 0, 0, 1, 1, 16'h0000, 12'h3F0, pack(0, 12'h000, 0, 1, 12'h3F0, 1, 16'h1234, 1, 0));
    vecs[8]  = mk("fetch_jumped", 0, 1, 1, 0, 0, 16'h5678, 12'h000, pack(1, 12'h3F0, 1, 0, 12'h000, 0, 16'h1234, 1, 0));
    vecs[9]  = mk("stall_1",      0, 0, 0, 0, 0, 16'h0000, 12'h000, pack(0, 12'h000, 0, 0, 12'h000, 1, 16'h5678, 1, 0));
    vecs[10] = mk("stall_2_jump", 0, 0, 0, 0, 1, 16'h0000, 12'h055, pack(0, 12'h000, 0, 0, 12'h000, 1, 16'h5678, 1, 0));
    vecs[11] = mk("hs_halted",    0, 0, 0, 1, 0, 16'h0000, 12'h000, pack(0, 12'h000, 0, 0, 12'h000, 1, 16'h5678, 1, 0));
    vecs[12] = mk("idle_halt",    0, 1, 0, 0, 0, 16'h0000, 12'h000, pack(0, 12'h000, 0, 0, 12'h000, 0, 16'h5678, 0, 0));
    vecs[13] = mk("restart",      1, 0, 0, 0, 0, 16'h0000, 12'h000, pack(0, 12'h000, 0, 0, 12'h000, 0, 16'h5678, 0, 0));
    vecs[14] = mk("fetch_resume", 0, 0, 1, 0, 0, 16'h9ABC, 12'h000, pack(1, 12'h3F1, 1, 0, 12'h000, 0, 16'h5678, 1, 0));
    vecs[15] = mk("issue_resume", 0, 0, 0, 1, 0, 16'h0000, 12'h000, pack(0, 12'h000, 0, 0, 12'h000, 1, 16'h9ABC, 1, 0));

    @(negedge clock);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clock);
      drive(vecs[i].start, vecs[i].halt, vecs[i].ack, vecs[i].ready, vecs[i].jen,
            vecs[i].mdata, vecs[i].jaddr);
      #1;
      check(vecs[i].name, 64'(outs()), 64'(vecs[i].exp));
    end
`ifdef FETCH_COUNT_EN
    check("count_after_table", 64'(fetchCount), 64'd4);
`endif

    // Memory never acks: 15 request cycles, then FAULT.
    n_req = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      drive(0, 0, 0, 0, 0, 16'h0, 12'h0);
      #1;
      if (i == 0) check("timeout_addr", 64'(memAddr), 64'h3F2);
      if (fault) break;
      if (memReq) n_req++;
    end
    check("timeout_req_cycles", 64'(n_req), 64'd15);
    check("fault_state", 64'({fault, memReq, instrValid, busy}), 64'b1001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(1, 1, 1, 1, 0, 16'h0, 12'h0);
    end
    #1;
    check("fault_sticky", 64'({fault, memReq, busy}), 64'b101);
    drive(0, 0, 0, 0, 0, 16'h0, 12'h0);
    @(negedge clock);
    #2 rst = 1'b0;
    #1;
    check("fault_async_clear", 64'({fault, busy}), 64'b00);

    // Asynchronous reset in the middle of an ISSUE with a jump strobe active.
    @(negedge clock);
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 16'h0, 12'h0);
    @(negedge clock);
    drive(0, 0, 1, 0, 0, 16'hBEEF, 12'h0);
    @(negedge clock);
    drive(0, 0, 0, 1, 1, 16'h0, 12'h2AA);
    #1;
    check("pre_reset_issue", 64'({instrValid, irData, pcWriteEn, pcDataIn}),
          64'({1'b1, 16'hBEEF, 1'b1, 12'h2AA}));
    #1 rst = 1'b0;
    #1;
    check("async_reset_outputs", 64'(outs()), 64'(pack(0, 0, 0, 0, 0, 0, 0, 0, 0)));
`ifdef FETCH_COUNT_EN
    check("async_reset_count", 64'(fetchCount), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
